bm_dag3_stim_sig: RTL

Self-checking driver and response reader for the bm_dag3 microbenchmark family. It generates pseudo-random stimulus for a_in/b_in/c_in/d_in and compacts the returned out0/out1 into a 16-bit MISR signature over a fixed run. It then compares the signature against an expected constant and reports pass/fail. It sits opposite the DAG datapath: it drives the DAG inputs and reads the DAG outputs, on the same clock.

---
 rtl/bm_dag3_stim_sig.sv | 129 ++++++++++++
 1 files changed

// File: rtl/bm_dag3_stim_sig.sv
// rtl/bm_dag3_stim_sig.sv - LFSR stimulus driver and MISR signature reader for the bm_dag3 DAG
//
// Drives pseudo-random vectors into a DAG datapath and compacts its responses
// into a 16-bit MISR over one run. At the end it compares the signature
// against a golden value.
//
// Ports:
//   clock       rising-edge clock
//   reset       synchronous, active-high reset
//   start       run request, accepted in IDLE and DONE only
//   a_in_o      registered stimulus to DAG a_in  (BITS)
//   b_in_o      registered stimulus to DAG b_in  (BITS)
//   c_in_o      registered stimulus to DAG c_in
//   d_in_o      registered stimulus to DAG d_in
//   out0_i      DAG out0 response (BITS)
//   out1_i      DAG out1 response
//   busy        high while in RUN or DRAIN
//   done        high while in DONE
//   pass        signature matches EXPECTED_SIG, qualified by done
//   signature   MISR contents
//   vec_count   vectors issued in the current run
module bm_dag3_stim_sig #(
    parameter int          BITS         = 2,
    parameter int          NUM_VECTORS  = 64,
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter logic [15:0] EXPECTED_SIG = 16'h0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    output logic [BITS-1:0] a_in_o,
    output logic [BITS-1:0] b_in_o,
    output logic            c_in_o,
    output logic            d_in_o,
    input  logic [BITS-1:0] out0_i,
    input  logic            out1_i,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [15:0]     signature,
    output logic [15:0]     vec_count
);

    localparam logic [15:0] NUM_VEC = 16'(NUM_VECTORS);
    localparam logic [7:0]  NUM_DRN = 8'(DRAIN_CYCLES);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic [7:0]  drain_cnt;
    logic [15:0] misr_in;
    logic [15:0] misr_next;

    // Shared by the LFSR and the MISR: same taps, shift left.
    function automatic logic [15:0] shift_fb(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Response packed as {zero pad, out1, out0} in the low bits.
    assign misr_in   = 16'({out1_i, out0_i});
    assign misr_next = shift_fb(signature) ^ misr_in;

    assign pass = done && (signature == EXPECTED_SIG);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            lfsr      <= LFSR_SEED;
            a_in_o    <= '0;
            b_in_o    <= '0;
            c_in_o    <= 1'b0;
            d_in_o    <= 1'b0;
            signature <= '0;
            vec_count <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // Always start from the seed so every run reproduces the first.
                    if (start) begin
                        state     <= RUN;
                        a_in_o    <= LFSR_SEED[BITS-1:0];
                        b_in_o    <= LFSR_SEED[2*BITS-1:BITS];
                        c_in_o    <= LFSR_SEED[2*BITS];
                        d_in_o    <= LFSR_SEED[2*BITS+1];
                        lfsr      <= shift_fb(LFSR_SEED);
                        vec_count <= 16'd1;
                        signature <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                RUN: begin
                    signature <= misr_next;
                    if (vec_count < NUM_VEC) begin
                        a_in_o    <= lfsr[BITS-1:0];
                        b_in_o    <= lfsr[2*BITS-1:BITS];
                        c_in_o    <= lfsr[2*BITS];
                        d_in_o    <= lfsr[2*BITS+1];
                        lfsr      <= shift_fb(lfsr);
                        vec_count <= vec_count + 16'd1;
                    end else begin
                        a_in_o    <= '0;
                        b_in_o    <= '0;
                        c_in_o    <= 1'b0;
                        d_in_o    <= 1'b0;
                        drain_cnt <= NUM_DRN;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    signature <= misr_next;
                    drain_cnt <= drain_cnt - 8'd1;
                    if (drain_cnt == 8'd1) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
